// File: rtl/crc_pkg.sv
// Shared types and CRC-32 (reflected) constants for the CRC engine slice.
package crc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        FINISH
    } state_t;

    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_XOROUT    = 32'hFFFFFFFF;

endpackage

// File: rtl/crc_byte_step.sv
// One-byte reflected (LSb-first) CRC update; passes crc_in through when en is low.
module crc_byte_step
    import crc_pkg::*;
#(
    parameter logic [31:0] POLY = CRC32_POLY_REFL
) (
    input  logic [31:0] crc_in,
    input  logic [7:0]  byte_in,
    input  logic        en,
    output logic [31:0] crc_out
);

    logic [31:0] c;
    logic [7:0]  d;

    always_comb begin
        c = crc_in;
        d = byte_in;
        for (int unsigned i = 0; i < 8; i++) begin
            if (c[0] ^ d[0]) begin
                c = (c >> 1) ^ POLY;
            end else begin
                c = c >> 1;
            end
            d = d >> 1;
        end
        crc_out = en ? c : crc_in;
    end

endmodule

// File: rtl/crc_engine_param.sv
// Multicycle reflected CRC-32 engine: accepts a frame on valid&&ready, folds BPC bytes
// per cycle (byte 0 at the MSB end of data_raw), then reports crc/match with a done pulse.
module crc_engine_param
    import crc_pkg::*;
#(
    parameter int unsigned FRAME_BYTES = 40,
    parameter int unsigned BPC         = 1,
    parameter logic [31:0] POLY        = CRC32_POLY_REFL,
    parameter logic [31:0] INIT        = CRC32_INIT,
    parameter logic [31:0] XOROUT      = CRC32_XOROUT
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               valid,
    output logic                               ready,
    input  logic [8*FRAME_BYTES-1:0]           data_raw,
    input  logic [$clog2(FRAME_BYTES+1)-1:0]   len,
    input  logic                               check_en,
    input  logic [31:0]                        crc_expected,
    output logic [31:0]                        crc,
    output logic                               done,
    output logic                               match,
    output logic                               busy
);

    localparam int unsigned LW = $clog2(FRAME_BYTES + 1);
    localparam int unsigned CW = $clog2(FRAME_BYTES + BPC);

    state_t                   state, state_nx;
    logic [8*FRAME_BYTES-1:0] data_q;
    logic [LW-1:0]            len_q;
    logic [LW-1:0]            len_clamped;
    logic                     check_q;
    logic [31:0]              exp_q;
    logic [31:0]              crc_reg;
    logic [31:0]              crc_final;
    logic [CW-1:0]            byte_cnt;
    logic                     accept;
    logic                     last_beat;
    logic [31:0]              chain [0:BPC];

    assign ready       = (state == IDLE) && !rst;
    assign busy        = (state != IDLE);
    assign accept      = valid && ready;
    assign len_clamped = (32'(len) > FRAME_BYTES) ? LW'(FRAME_BYTES) : len;
    assign last_beat   = (32'(byte_cnt) + BPC) >= 32'(len_q);
    assign crc_final   = crc_reg ^ XOROUT;
    assign chain[0]    = crc_reg;

    // Lanes past len are bypassed, so the index is only guarded to keep the select in range.
    for (genvar g = 0; g < BPC; g++) begin : g_step
        logic [31:0] idx;
        logic [7:0]  lane_byte;
        logic        lane_en;

        assign idx       = 32'(byte_cnt) + g;
        assign lane_en   = idx < 32'(len_q);
        assign lane_byte = (idx < FRAME_BYTES) ? data_q[8*FRAME_BYTES-1-8*idx -: 8] : '0;

        crc_byte_step #(
            .POLY(POLY)
        ) u_step (
            .crc_in (chain[g]),
            .byte_in(lane_byte),
            .en     (lane_en),
            .crc_out(chain[g+1])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nx = (len_clamped == '0) ? FINISH : COMPUTE;
                end
            end
            COMPUTE: begin
                if (last_beat) begin
                    state_nx = FINISH;
                end
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q   <= '0;
            len_q    <= '0;
            check_q  <= 1'b0;
            exp_q    <= '0;
            crc_reg  <= INIT;
            byte_cnt <= '0;
            crc      <= '0;
            done     <= 1'b0;
            match    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        data_q   <= data_raw;
                        len_q    <= len_clamped;
                        check_q  <= check_en;
                        exp_q    <= crc_expected;
                        crc_reg  <= INIT;
                        byte_cnt <= '0;
                    end
                end
                COMPUTE: begin
                    crc_reg  <= chain[BPC];
                    byte_cnt <= byte_cnt + CW'(BPC);
                end
                FINISH: begin
                    crc   <= crc_final;
                    match <= check_q && (crc_final == exp_q);
                    done  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_crc_engine_param.sv
// Directed bench for crc_engine_param: BPC=1 and BPC=4 instances checked against
// hand-computed CRC-32 values and a small bitwise reference for random frames.
module tb_crc_engine_param;

    localparam int unsigned FB = 40;
    localparam int unsigned LW = $clog2(FB + 1);

    logic            clk = 1'b0;
    logic            rst;
    logic            valid1, valid4;
    logic [8*FB-1:0] data;
    logic [LW-1:0]   len;
    logic            check_en;
    logic [31:0]     crc_exp;

    logic        ready1, done1, match1, busy1;
    logic        ready4, done4, match4, busy4;
    logic [31:0] crc1, crc4;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    crc_engine_param #(.FRAME_BYTES(FB), .BPC(1)) u_dut1 (
        .clk(clk), .rst(rst), .valid(valid1), .ready(ready1), .data_raw(data), .len(len),
        .check_en(check_en), .crc_expected(crc_exp), .crc(crc1), .done(done1),
        .match(match1), .busy(busy1)
    );

    crc_engine_param #(.FRAME_BYTES(FB), .BPC(4)) u_dut4 (
        .clk(clk), .rst(rst), .valid(valid4), .ready(ready4), .data_raw(data), .len(len),
        .check_en(check_en), .crc_expected(crc_exp), .crc(crc4), .done(done4),
        .match(match4), .busy(busy4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_model(input logic [8*FB-1:0] d, input int unsigned n);
        logic [31:0] c;
        logic [7:0]  b;
        c = 32'hFFFFFFFF;
        for (int unsigned k = 0; k < n; k++) begin
            b = d[8*FB-1-8*k -: 8];
            for (int unsigned i = 0; i < 8; i++) begin
                if (c[0] ^ b[0]) c = (c >> 1) ^ 32'hEDB88320;
                else             c = c >> 1;
                b = b >> 1;
            end
        end
        return c ^ 32'hFFFFFFFF;
    endfunction

    function automatic logic [8*FB-1:0] rand_frame();
        logic [8*FB-1:0] d;
        for (int unsigned k = 0; k < FB; k++) d[8*k +: 8] = 8'($urandom_range(0, 255));
        return d;
    endfunction

    // Drives one frame into both engines, scrambles the inputs after accept, and checks results.
    task automatic run_frame(input string tag, input logic [8*FB-1:0] d, input logic [LW-1:0] l,
                             input logic ce, input logic [31:0] ce_exp, input logic [31:0] want_crc,
                             input logic want_match, input int lat1, input int lat4);
        int          seen1, seen4, at1, at4;
        logic [31:0] c1, c4;
        logic        m1, m4;
        seen1 = 0; seen4 = 0; at1 = -1; at4 = -1; c1 = '0; c4 = '0; m1 = 1'b0; m4 = 1'b0;
        @(negedge clk);
        data = d; len = l; check_en = ce; crc_exp = ce_exp;
        valid1 = 1'b1; valid4 = 1'b1;
        check({tag, "_ready1"}, ready1, 1);
        check({tag, "_ready4"}, ready4, 1);
        @(negedge clk);
        valid1 = 1'b0; valid4 = 1'b0;
        data = ~data; len = '0; check_en = ~check_en; crc_exp = ~crc_exp;
        for (int cyc = 1; cyc <= int'(FB) + 6; cyc++) begin
            @(negedge clk);
            if (done1) begin
                seen1++;
                if (at1 < 0) begin at1 = cyc; c1 = crc1; m1 = match1; end
            end
            if (done4) begin
                seen4++;
                if (at4 < 0) begin at4 = cyc; c4 = crc4; m4 = match4; end
            end
        end
        check({tag, "_crc1"}, c1, want_crc);
        check({tag, "_crc4"}, c4, want_crc);
        check({tag, "_match1"}, m1, want_match);
        check({tag, "_match4"}, m4, want_match);
        check({tag, "_lat1"}, at1, lat1);
        check({tag, "_lat4"}, at4, lat4);
        check({tag, "_pulses1"}, seen1, 1);
        check({tag, "_pulses4"}, seen4, 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        logic [8*FB-1:0] d9, dr;
        int              cnt1, cnt4, first_at, second_at, pulses;
        logic [31:0]     first_crc, second_crc;

        d9 = '0;
        d9[8*FB-1 -: 72] = 72'h313233343536373839;

        rst = 1'b1; valid1 = 1'b0; valid4 = 1'b0;
        data = '0; len = '0; check_en = 1'b0; crc_exp = '0;
        repeat (2) @(negedge clk);
        check("rst_crc1", crc1, 0);
        check("rst_done1", done1, 0);
        check("rst_match4", match4, 0);
        check("rst_busy1", busy1, 0);
        check("rst_ready1", ready1, 0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready4", ready4, 1);
        check("post_rst_crc4", crc4, 0);

        run_frame("std",     d9, LW'(9), 1'b0, 32'h0,        32'hCBF43926, 1'b0, 10, 4);
        run_frame("chk_ok",  d9, LW'(9), 1'b1, 32'hCBF43926, 32'hCBF43926, 1'b1, 10, 4);
        run_frame("chk_bad", d9, LW'(9), 1'b1, 32'hCBF43927, 32'hCBF43926, 1'b0, 10, 4);
        run_frame("len1",    '0, LW'(1), 1'b0, 32'h0,        32'hD202EF8D, 1'b0, 2, 2);
        dr = rand_frame();
        run_frame("len0",    dr, LW'(0), 1'b1, 32'h00000000, 32'h00000000, 1'b1, 1, 1);
        dr = rand_frame();
        run_frame("len13",   dr, LW'(13), 1'b0, 32'h0, crc_model(dr, 13), 1'b0, 14, 5);
        dr = rand_frame();
        run_frame("clamp50", dr, LW'(50), 1'b0, 32'h0, crc_model(dr, 40), 1'b0, 41, 11);

        // Reset during the fifth beat of a full-length frame.
        @(negedge clk);
        data = rand_frame(); len = LW'(40); check_en = 1'b0; valid1 = 1'b1; valid4 = 1'b1;
        @(negedge clk);
        valid1 = 1'b0; valid4 = 1'b0;
        repeat (4) @(negedge clk);
        check("abort_busy_before", busy1, 1);
        rst = 1'b1;
        #1;
        check("abort_crc1", crc1, 0);
        check("abort_crc4", crc4, 0);
        check("abort_busy4", busy4, 0);
        check("abort_ready1", ready1, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_ready_rel1", ready1, 1);
        check("abort_ready_rel4", ready4, 1);
        cnt1 = 0; cnt4 = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            @(negedge clk);
            if (done1) cnt1++;
            if (done4) cnt4++;
        end
        check("abort_nodone1", cnt1, 0);
        check("abort_nodone4", cnt4, 0);
        dr = rand_frame();
        run_frame("after_abort", dr, LW'(40), 1'b0, 32'h0, crc_model(dr, 40), 1'b0, 41, 11);

        // valid held through compute on the BPC=4 engine; the next accept lands on the done cycle.
        @(negedge clk);
        data = d9; len = LW'(9); check_en = 1'b0; crc_exp = '0; valid4 = 1'b1;
        @(negedge clk);
        data = '0; len = LW'(1);
        first_at = -1; second_at = -1; pulses = 0; first_crc = '0; second_crc = '0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(negedge clk);
            if (done4) begin
                pulses++;
                if (first_at < 0) begin
                    first_at = cyc; first_crc = crc4;
                    check("b2b_ready_on_done", ready4, 1);
                end else if (second_at < 0) begin
                    second_at = cyc; second_crc = crc4;
                end
            end
            if (cyc == 2) check("b2b_busy_mid", busy4, 1);
            if (cyc == 5) begin
                check("b2b_busy_restart", busy4, 1);
                valid4 = 1'b0;
            end
        end
        check("b2b_first_crc", first_crc, 32'hCBF43926);
        check("b2b_first_lat", first_at, 4);
        check("b2b_second_crc", second_crc, 32'hD202EF8D);
        check("b2b_second_lat", second_at, 7);
        check("b2b_pulses", pulses, 2);
        check("b2b_idle_other", busy1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
